// File: rtl/riscape_pkg.sv
// Shared types for the riscape memory arbiter.
// Arbiter states, grant encoding and the grant priority rule.
package riscape_pkg;

  typedef enum logic [1:0] {
    IDLE,
    IACC,
    DACC
  } arb_state_t;

  typedef enum logic {
    GRANT_FETCH,
    GRANT_DATA
  } grant_t;

  // Data wins unless it won last time and fetch is also waiting.
  function automatic logic data_wins(
    input logic   dreq,
    input logic   ireq,
    input grant_t last
  );
    return dreq && !((last == GRANT_DATA) && ireq);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Memory-side bus of the unified I/D memory arbiter.
// master = arbiter, slave = memory.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_be;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    output mem_be,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    input  mem_be,
    output mem_rdata,
    output mem_ready
  );

endinterface

// File: rtl/wait_timer.sv
// Saturating wait-state counter for the memory arbiter.
// expired is high while the count equals TIMEOUT.
module wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Unified instruction/data memory arbiter for the RV32 pipeline.
// Grants F and M stage accesses onto one registered memory port.
module mem_arbiter
  import riscape_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                IReqF,
  input  logic [ADDR_W-1:0]   IAddrF,
  input  logic                DReqM,
  input  logic                DWeM,
  input  logic [ADDR_W-1:0]   DAddrM,
  input  logic [DATA_W-1:0]   DWDataM,
  input  logic [DATA_W/8-1:0] DBeM,
  mem_arbiter_if.master       mem,
  output logic [DATA_W-1:0]   InstrF,
  output logic                IValidF,
  output logic [DATA_W-1:0]   ReadDataM,
  output logic                DValidM,
  output logic                StallF,
  output logic                StallM,
  output logic                bus_err
);

  arb_state_t state;
  grant_t     last_grant;

  logic busy;
  logic done;
  logic expired;
  logic pick_d;
  logic pick_i;
  logic grant;

  assign busy   = (state != IDLE);
  assign done   = !busy || mem.mem_ready || expired;
  assign pick_d = data_wins(DReqM, IReqF, last_grant);
  assign pick_i = IReqF && !pick_d;
  assign grant  = done && (pick_d || pick_i);

  wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (grant),
    .en      (busy && !mem.mem_ready),
    .expired (expired)
  );

  assign StallF = IReqF && !IValidF;
  assign StallM = DReqM && !DValidM;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      last_grant    <= GRANT_FETCH;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      mem.mem_be    <= '0;
      InstrF        <= '0;
      IValidF       <= 1'b0;
      ReadDataM     <= '0;
      DValidM       <= 1'b0;
      bus_err       <= 1'b0;
    end else begin
      IValidF <= 1'b0;
      DValidM <= 1'b0;

      // Completion or abort: an aborted access returns zero data.
      if (busy && done) begin
        if (state == IACC) begin
          InstrF  <= mem.mem_ready ? mem.mem_rdata : '0;
          IValidF <= 1'b1;
        end else begin
          if (!mem.mem_we) begin
            ReadDataM <= mem.mem_ready ? mem.mem_rdata : '0;
          end
          DValidM <= 1'b1;
        end
        if (!mem.mem_ready) begin
          bus_err <= 1'b1;
        end
      end

      if (done) begin
        unique case (1'b1)
          pick_d: begin
            state         <= DACC;
            last_grant    <= GRANT_DATA;
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= DWeM;
            mem.mem_addr  <= DAddrM;
            mem.mem_wdata <= DWDataM;
            mem.mem_be    <= DBeM;
          end
          pick_i: begin
            state        <= IACC;
            last_grant   <= GRANT_FETCH;
            mem.mem_req  <= 1'b1;
            mem.mem_we   <= 1'b0;
            mem.mem_addr <= IAddrF;
          end
          default: begin
            state       <= IDLE;
            mem.mem_req <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter (TIMEOUT = 4).
// Each task drives one scenario and checks hand-computed values.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          IReqF;
  logic [AW-1:0] IAddrF;
  logic          DReqM;
  logic          DWeM;
  logic [AW-1:0] DAddrM;
  logic [DW-1:0] DWDataM;
  logic [3:0]    DBeM;
  logic [DW-1:0] InstrF;
  logic          IValidF;
  logic [DW-1:0] ReadDataM;
  logic          DValidM;
  logic          StallF;
  logic          StallM;
  logic          bus_err;

  int checks = 0;
  int errors = 0;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mbus ();

  mem_arbiter #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .IReqF     (IReqF),
    .IAddrF    (IAddrF),
    .DReqM     (DReqM),
    .DWeM      (DWeM),
    .DAddrM    (DAddrM),
    .DWDataM   (DWDataM),
    .DBeM      (DBeM),
    .mem       (mbus.master),
    .InstrF    (InstrF),
    .IValidF   (IValidF),
    .ReadDataM (ReadDataM),
    .DValidM   (DValidM),
    .StallF    (StallF),
    .StallM    (StallM),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    IReqF = 1'b0; IAddrF = '0;
    DReqM = 1'b0; DWeM = 1'b0;
    DAddrM = '0; DWDataM = '0; DBeM = '0;
    mbus.mem_ready = 1'b0;
    mbus.mem_rdata = '0;
    #12;
    checks++;
    if ({mbus.mem_req, mbus.mem_we, IValidF, DValidM, bus_err} !== 5'b0) begin
      errors++;
      $display("FAIL rst_flags: got %b want 00000",
        {mbus.mem_req, mbus.mem_we, IValidF, DValidM, bus_err});
    end
    checks++;
    if ({mbus.mem_addr, InstrF, ReadDataM} !== 96'h0) begin
      errors++;
      $display("FAIL rst_data: got %h want 0",
        {mbus.mem_addr, InstrF, ReadDataM});
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
    checks++;
    if (mbus.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_idle: got %b want 0", mbus.mem_req);
    end
  endtask

  task automatic test_zero_wait_fetch;
    IAddrF = 32'h100; IReqF = 1'b1;
    mbus.mem_ready = 1'b1;
    mbus.mem_rdata = 32'h00500093;
    #1;
    checks++;
    if (StallF !== 1'b1) begin
      errors++;
      $display("FAIL zw_stall_t: got %b want 1", StallF);
    end
    tick();
    checks++;
    if ({mbus.mem_req, mbus.mem_we, IValidF, StallF} !== 4'b1001) begin
      errors++;
      $display("FAIL zw_t1_flags: got %b want 1001",
        {mbus.mem_req, mbus.mem_we, IValidF, StallF});
    end
    checks++;
    if (mbus.mem_addr !== 32'h100) begin
      errors++;
      $display("FAIL zw_addr: got %h want 00000100", mbus.mem_addr);
    end
    tick();
    checks++;
    if ({IValidF, StallF} !== 2'b10) begin
      errors++;
      $display("FAIL zw_t2_flags: got %b want 10", {IValidF, StallF});
    end
    checks++;
    if (InstrF !== 32'h00500093) begin
      errors++;
      $display("FAIL zw_instr: got %h want 00500093", InstrF);
    end
    IReqF = 1'b0;
    tick();
    tick();
    checks++;
    if ({mbus.mem_req, IValidF} !== 2'b00) begin
      errors++;
      $display("FAIL zw_drain: got %b want 00", {mbus.mem_req, IValidF});
    end
  endtask

  task automatic test_contention;
    DAddrM = 32'h3000; DWeM = 1'b0; DBeM = 4'hF; DWDataM = '0;
    IAddrF = 32'h104;
    mbus.mem_ready = 1'b1;
    mbus.mem_rdata = 32'h11111111;
    DReqM = 1'b1; IReqF = 1'b1;
    tick();
    checks++;
    if (mbus.mem_addr !== 32'h3000) begin
      errors++;
      $display("FAIL ct_g1_data: got %h want 00003000", mbus.mem_addr);
    end
    tick();
    checks++;
    if ({DValidM, ReadDataM, mbus.mem_addr} !== {1'b1, 32'h11111111, 32'h104}) begin
      errors++;
      $display("FAIL ct_g2_fetch: got %b %h %h want 1 11111111 00000104",
        DValidM, ReadDataM, mbus.mem_addr);
    end
    mbus.mem_rdata = 32'h22222222;
    tick();
    checks++;
    if ({IValidF, DValidM, InstrF, mbus.mem_addr}
        !== {2'b10, 32'h22222222, 32'h3000}) begin
      errors++;
      $display("FAIL ct_g3_data: got %b%b %h %h want 10 22222222 00003000",
        IValidF, DValidM, InstrF, mbus.mem_addr);
    end
    mbus.mem_rdata = 32'h33333333;
    tick();
    checks++;
    if ({DValidM, ReadDataM, mbus.mem_addr} !== {1'b1, 32'h33333333, 32'h104}) begin
      errors++;
      $display("FAIL ct_g4_fetch: got %b %h %h want 1 33333333 00000104",
        DValidM, ReadDataM, mbus.mem_addr);
    end
    IReqF = 1'b0; DReqM = 1'b0;
    tick();
    checks++;
    if ({mbus.mem_req, IValidF, InstrF} !== {2'b01, 32'h33333333}) begin
      errors++;
      $display("FAIL ct_end: got %b%b %h want 01 33333333",
        mbus.mem_req, IValidF, InstrF);
    end
  endtask

  task automatic test_store_wait;
    DWeM = 1'b1; DAddrM = 32'h2000;
    DWDataM = 32'hDEADBEEF; DBeM = 4'hF;
    mbus.mem_ready = 1'b0;
    mbus.mem_rdata = 32'h5A5A5A5A;
    DReqM = 1'b1;
    tick();
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) mbus.mem_ready = 1'b1;
      #1;
      checks++;
      if ({mbus.mem_req, mbus.mem_we, mbus.mem_addr, mbus.mem_wdata, mbus.mem_be}
          !== {2'b11, 32'h2000, 32'hDEADBEEF, 4'hF}) begin
        errors++;
        $display("FAIL st_hold%0d: got %b%b %h %h %h", c,
          mbus.mem_req, mbus.mem_we, mbus.mem_addr, mbus.mem_wdata, mbus.mem_be);
      end
      checks++;
      if ({DValidM, StallM} !== 2'b01) begin
        errors++;
        $display("FAIL st_wait%0d: got %b want 01", c, {DValidM, StallM});
      end
      tick();
    end
    checks++;
    if ({DValidM, StallM, ReadDataM} !== {2'b10, 32'h33333333}) begin
      errors++;
      $display("FAIL st_done: got %b%b %h want 10 33333333",
        DValidM, StallM, ReadDataM);
    end
    DReqM = 1'b0;
    tick();
    tick();
    checks++;
    if ({mbus.mem_req, DValidM, ReadDataM} !== {2'b00, 32'h33333333}) begin
      errors++;
      $display("FAIL st_idle: got %b%b %h want 00 33333333",
        mbus.mem_req, DValidM, ReadDataM);
    end
    DWeM = 1'b0;
  endtask

  task automatic test_timeout;
    checks++;
    if (bus_err !== 1'b0) begin
      errors++;
      $display("FAIL to_pre: got %b want 0", bus_err);
    end
    IAddrF = 32'h200; IReqF = 1'b1;
    mbus.mem_ready = 1'b0;
    mbus.mem_rdata = 32'hFFFFFFFF;
    tick();
    for (int c = 1; c <= 5; c++) begin
      checks++;
      if ({mbus.mem_req, IValidF, bus_err} !== 3'b100) begin
        errors++;
        $display("FAIL to_wait%0d: got %b want 100", c,
          {mbus.mem_req, IValidF, bus_err});
      end
      tick();
    end
    checks++;
    if ({IValidF, bus_err, mbus.mem_req, InstrF} !== {3'b111, 32'h0}) begin
      errors++;
      $display("FAIL to_abort: got %b%b%b %h want 111 00000000",
        IValidF, bus_err, mbus.mem_req, InstrF);
    end
    IReqF = 1'b0;
    mbus.mem_rdata = 32'h00000013;
    mbus.mem_ready = 1'b1;
    tick();
    checks++;
    if ({IValidF, bus_err, mbus.mem_req, InstrF} !== {3'b110, 32'h13}) begin
      errors++;
      $display("FAIL to_sticky: got %b%b%b %h want 110 00000013",
        IValidF, bus_err, mbus.mem_req, InstrF);
    end
    tick();
  endtask

  task automatic test_reset_mid;
    DWeM = 1'b0; DAddrM = 32'h4000; DReqM = 1'b1;
    mbus.mem_ready = 1'b0;
    tick();
    checks++;
    if ({mbus.mem_req, mbus.mem_addr} !== {1'b1, 32'h4000}) begin
      errors++;
      $display("FAIL rm_grant: got %b %h want 1 00004000",
        mbus.mem_req, mbus.mem_addr);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({mbus.mem_req, bus_err, mbus.mem_addr, InstrF, ReadDataM}
        !== {2'b00, 96'h0}) begin
      errors++;
      $display("FAIL rm_clear: got %b%b %h %h %h want all 0",
        mbus.mem_req, bus_err, mbus.mem_addr, InstrF, ReadDataM);
    end
    DReqM = 1'b0;
    IAddrF = 32'h300; IReqF = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    tick();
    checks++;
    if ({mbus.mem_req, mbus.mem_we, mbus.mem_addr} !== {2'b10, 32'h300}) begin
      errors++;
      $display("FAIL rm_fetch: got %b%b %h want 10 00000300",
        mbus.mem_req, mbus.mem_we, mbus.mem_addr);
    end
    IReqF = 1'b0;
    mbus.mem_ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_withdrawn;
    IAddrF = 32'h400; IReqF = 1'b1;
    mbus.mem_ready = 1'b0;
    tick();
    DAddrM = 32'h5000; DReqM = 1'b1;
    #1;
    checks++;
    if (StallM !== 1'b1) begin
      errors++;
      $display("FAIL wd_stall_hi: got %b want 1", StallM);
    end
    tick();
    DReqM = 1'b0;
    #1;
    checks++;
    if ({StallM, mbus.mem_req, mbus.mem_addr} !== {2'b01, 32'h400}) begin
      errors++;
      $display("FAIL wd_stall_lo: got %b%b %h want 01 00000400",
        StallM, mbus.mem_req, mbus.mem_addr);
    end
    mbus.mem_rdata = 32'h00000099;
    mbus.mem_ready = 1'b1;
    tick();
    checks++;
    if ({IValidF, DValidM, mbus.mem_we, InstrF, mbus.mem_addr}
        !== {3'b100, 32'h99, 32'h400}) begin
      errors++;
      $display("FAIL wd_done: got %b%b%b %h %h want 100 00000099 00000400",
        IValidF, DValidM, mbus.mem_we, InstrF, mbus.mem_addr);
    end
    IReqF = 1'b0;
    tick();
    checks++;
    if ({mbus.mem_req, DValidM} !== 2'b00) begin
      errors++;
      $display("FAIL wd_idle: got %b want 00", {mbus.mem_req, DValidM});
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait_fetch();
    test_contention();
    test_store_wait();
    test_timeout();
    test_reset_mid();
    test_withdrawn();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter for the pipelined RV32 core. Shares one unified instruction/data memory between the fetch stage (F) and the memory stage (M). It sequences each access through a registered request/ready handshake, returns read data with a one-cycle valid pulse, drives per-stage stall outputs to the hazard logic, and flags memory accesses that never complete.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width; byte-enable width is `DATA_W/8`.
- `TIMEOUT`, default 255: maximum wait cycles with `mem_ready` low before the access is aborted; must be ≥ 1.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `IReqF`  in  1  fetch request; held high until `IValidF`.
- `IAddrF`  in  ADDR_W  fetch address; stable while `IReqF` is high.
- `DReqM`  in  1  data request; held high until `DValidM`.
- `DWeM`  in  1  data write (1) or read (0).
- `DAddrM`  in  ADDR_W  data address.
- `DWDataM`  in  DATA_W  write data.
- `DBeM`  in  DATA_W/8  byte enables.
- `mem_req`, `mem_we`  out  1  memory strobe and write select (registered).
- `mem_addr`  out  ADDR_W  latched address.
- `mem_wdata`  out  DATA_W  latched write data.
- `mem_be`  out  DATA_W/8  latched byte enables.
- `mem_rdata`  in  DATA_W  memory read data; valid when `mem_ready` is high.
- `mem_ready`  in  1  access completes this cycle.
- `InstrF`  out  DATA_W  fetched instruction (registered).
- `IValidF`  out  1  one-cycle pulse; `InstrF` is valid.
- `ReadDataM`  out  DATA_W  load data (registered).
- `DValidM`  out  1  one-cycle pulse; data access done.
- `StallF`, `StallM`  out  1  stall requests to the hazard unit.
- `bus_err`  out  1  sticky timeout flag.

## Operation
- FSM states: `IDLE`, `IACC`, `DACC`.
- **Arbitration.** Arbitration is evaluated in `IDLE`, and also in the completion/abort cycle of `IACC`/`DACC`, so back-to-back grants are possible.
  - Data wins unless `last_grant`==DATA and `IReqF` is also pending. In that case fetch wins, which alternates grants under contention.
  - No pending request: go to `IDLE`.
- **Grant.** On a grant, register the address (and, for data, `DWeM`, `DWDataM`, `DBeM`) onto the `mem_*` outputs. Set `mem_req`=1, update `last_grant`, and clear the wait counter.
- **Waiting.** In `IACC`/`DACC`, `mem_req` and all `mem_*` outputs are held constant until `mem_ready`=1.
  - On `mem_ready`: capture `mem_rdata` into `InstrF` (IACC) or into `ReadDataM` (DACC read only). Pulse `IValidF` or `DValidM` in the next cycle.
  - Writes pulse `DValidM`; `ReadDataM` is unchanged.
  - If no new grant is made, drop `mem_req`.
- **Timeout.** The wait counter increments in each `IACC`/`DACC` cycle with `mem_ready`=0. When it reaches `TIMEOUT`, the access is aborted:
  - `bus_err` is set (sticky until reset).
  - The valid pulse is still issued, with captured data forced to 0.
  - Arbitration proceeds as on a normal completion.
- **Stalls** (combinational):
  - `StallF` = `IReqF` & ~(`IValidF`).
  - `StallM` = `DReqM` & ~(`DValidM`).
- A request withdrawn before its grant is ignored. Withdrawal after grant is illegal; the access completes anyway.
- **Reset** (any time, including mid-access): state `IDLE`, `last_grant`=FETCH, all outputs 0, counter 0, `bus_err` 0. An in-flight memory access is abandoned.

## Timing
- Zero-wait memory (`mem_ready` high in the first `mem_req` cycle): request seen at edge t → `mem_req` high in cycle t+1 → valid pulse in cycle t+2. Minimum latency is 2 cycles.
- N wait states add N cycles.
- Sustained throughput is one access per `mem_ready` cycle when requests stay pending.
- A valid pulse is exactly one cycle wide.
- `mem_*` outputs change only on the grant edge.
- Abort happens on the edge where the counter equals `TIMEOUT`, i.e. `TIMEOUT`+1 cycles of `mem_req` with `mem_ready` low.
- Counter width is `$clog2(TIMEOUT+1)`; the counter saturates and never wraps.

## Structure
- Shared package `riscape_pkg` contains:
  - `typedef enum logic [1:0] {IDLE, IACC, DACC} arb_state_t`.
  - `typedef enum logic {GRANT_FETCH, GRANT_DATA} grant_t`.
- One sub-module, `wait_timer`: clear/enable inputs and a `TIMEOUT` parameter, with a saturating counter and an `expired` output.
- Flops use the asynchronous active-low `reset`.

## Test plan
- Zero-wait fetch: `IAddrF`=0x100, `IReqF`=1, `mem_ready`=1, `mem_rdata`=0x00500093 → `mem_addr`=0x100 at t+1, `IValidF`=1 with `InstrF`=0x00500093 at t+2, `StallF` high for cycles t and t+1.
- Contention: `IReqF` and `DReqM` rise together with `last_grant`=FETCH → data is granted first (`mem_addr`=`DAddrM`), then fetch is granted back-to-back. With both held continuously, grants alternate D, I, D, I.
- Store with wait states: `DWeM`=1, `DAddrM`=0x2000, `DWDataM`=0xDEADBEEF, `DBeM`=0xF, `mem_ready` low for 3 cycles → `mem_*` outputs stable for 4 cycles, one `DValidM` pulse, `ReadDataM` unchanged.
- Timeout with `TIMEOUT`=4: `mem_ready` held low → abort after 5 `mem_req` cycles, `IValidF` pulse with `InstrF`=0, `bus_err`=1 remaining set through later good accesses.
- Reset mid-access: deassert `reset` during `DACC` with `mem_req`=1 → all outputs 0 immediately. After release, state is `IDLE` and a pending `IReqF` is granted first.
- Withdrawn request: `DReqM` pulsed for one cycle while fetch is in `IACC` → no data grant occurs and `StallM` falls with it.
